// File: rtl/prio_pkg.sv
// Shared definitions for the priority encoder family: mode selectors and
// an elaboration-time ceil(log2) helper used to size index ports.
package prio_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational highest-set-bit finder: returns the index of the highest
// set bit in vec and a flag telling whether any bit was set at all.
module prio_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan so the last (highest) set bit overwrites earlier hits.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_q.sv
// Registered priority encoder with sticky request capture, fixed or
// round-robin selection, and a valid/ready output stage that holds under backpressure.
module prio_encoder_q
    import prio_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = PRIO_FIXED,
    parameter int STICKY  = 1,
    localparam int W      = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pending
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic         accept;
    logic         load;
    logic [N-1:0] clr;
    logic [N-1:0] capture;
    logic [N-1:0] cand;
    logic [N-1:0] low_mask;
    logic [W-1:0] last;
    logic [W-1:0] full_idx;
    logic         full_any;
    logic [W-1:0] low_idx;
    logic         low_any;
    logic [W-1:0] sel;

    assign accept  = out_valid & out_ready;
    assign load    = ~out_valid | out_ready;
    assign clr     = accept ? out_onehot : '0;
    assign capture = en ? req : '0;
    // The source being accepted this cycle must not be granted again from stale state.
    assign cand    = pending & ~clr;

    always_comb begin
        low_mask = '0;
        for (int i = 0; i < N; i++) begin
            low_mask[i] = (i < int'(last));
        end
    end

    prio_pick #(.N(N), .W(W)) u_pick_full (
        .vec (cand),
        .idx (full_idx),
        .any (full_any)
    );

    prio_pick #(.N(N), .W(W)) u_pick_low (
        .vec (cand & low_mask),
        .idx (low_idx),
        .any (low_any)
    );

    // Round-robin prefers sources below the last grant, otherwise wraps to the top.
    assign sel = (RR_MODE == PRIO_RR && low_any) ? low_idx : full_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            last       <= '0;
        end else begin
            if (STICKY != 0) begin
                pending <= (pending & ~clr) | capture;
            end else begin
                pending <= capture;
            end
            if (accept) begin
                last <= out_idx;
            end
            if (load) begin
                out_valid  <= full_any;
                out_idx    <= full_any ? sel : '0;
                out_onehot <= full_any ? (ONE << sel) : '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed bench: table-driven vectors on a fixed/sticky instance, plus
// hand-written sequences for round-robin/level mode and a non-power-of-2 width.
module tb_prio_encoder_q;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstA, enA, readyA, validA;
    logic [7:0] reqA, onehotA, pendA;
    logic [2:0] idxA;

    logic       rstB, enB, readyB, validB;
    logic [7:0] reqB, onehotB, pendB;
    logic [2:0] idxB;

    logic       rstC, enC, readyC, validC;
    logic [4:0] reqC, onehotC, pendC;
    logic [2:0] idxC;

    prio_encoder_q #(.N(8), .RR_MODE(0), .STICKY(1)) dutFixed (
        .clk(clk), .rst(rstA), .en(enA), .req(reqA), .out_ready(readyA),
        .out_valid(validA), .out_idx(idxA), .out_onehot(onehotA), .pending(pendA)
    );

    prio_encoder_q #(.N(8), .RR_MODE(1), .STICKY(0)) dutRr (
        .clk(clk), .rst(rstB), .en(enB), .req(reqB), .out_ready(readyB),
        .out_valid(validB), .out_idx(idxB), .out_onehot(onehotB), .pending(pendB)
    );

    prio_encoder_q #(.N(5), .RR_MODE(0), .STICKY(1)) dutOdd (
        .clk(clk), .rst(rstC), .en(enC), .req(reqC), .out_ready(readyC),
        .out_valid(validC), .out_idx(idxC), .out_onehot(onehotC), .pending(pendC)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       ready;
        logic [7:0] req;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] pend;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic void addVec(input logic r, input logic e, input logic rdy,
                                   input logic [7:0] q, input logic v,
                                   input logic [2:0] i, input logic [7:0] p);
        vec_t t;
        t.rst = r; t.en = e; t.ready = rdy; t.req = q;
        t.valid = v; t.idx = i; t.pend = p;
        vecs.push_back(t);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        rstA   = v.rst;
        enA    = v.en;
        readyA = v.ready;
        reqA   = v.req;
        tick();
    endtask

    initial begin
        logic [7:0] expOh;
        int exp85[6];

        rstA = 1; enA = 0; readyA = 1; reqA = '0;
        rstB = 1; enB = 0; readyB = 1; reqB = '0;
        rstC = 1; enC = 0; readyC = 1; reqC = '0;

        // reset with all requests high, then a single pulse draining 5,2,1
        addVec(1,1,1,8'hFF, 0,0,8'h00);
        addVec(1,1,1,8'hFF, 0,0,8'h00);
        addVec(0,1,1,8'h26, 0,0,8'h26);
        addVec(0,0,1,8'h00, 1,5,8'h26);
        addVec(0,0,1,8'h00, 1,2,8'h06);
        addVec(0,0,1,8'h00, 1,1,8'h02);
        addVec(0,0,1,8'h00, 0,0,8'h00);
        addVec(0,0,1,8'h00, 0,0,8'h00);
        // backpressure holds idx 5 while req[7] arrives
        addVec(0,1,1,8'h26, 0,0,8'h26);
        addVec(0,0,0,8'h00, 1,5,8'h26);
        addVec(0,1,0,8'h80, 1,5,8'hA6);
        addVec(0,0,0,8'h00, 1,5,8'hA6);
        addVec(0,0,1,8'h00, 1,7,8'h86);
        addVec(0,0,1,8'h00, 1,2,8'h06);
        addVec(0,0,1,8'h00, 1,1,8'h02);
        addVec(0,0,1,8'h00, 0,0,8'h00);
        // capture disabled, then one enabled cycle
        for (int i = 0; i < 4; i++) addVec(0,0,1,8'h10, 0,0,8'h00);
        addVec(0,1,1,8'h10, 0,0,8'h10);
        addVec(0,0,1,8'h10, 1,4,8'h10);
        addVec(0,0,1,8'h10, 0,0,8'h00);
        addVec(0,0,1,8'h00, 0,0,8'h00);
        // re-pulse of the source being accepted keeps it pending
        addVec(0,1,1,8'h08, 0,0,8'h08);
        addVec(0,0,1,8'h00, 1,3,8'h08);
        addVec(0,1,1,8'h08, 0,0,8'h08);
        addVec(0,0,1,8'h00, 1,3,8'h08);
        addVec(0,0,1,8'h00, 0,0,8'h00);
        addVec(0,0,1,8'h00, 0,0,8'h00);
        // reset mid-handshake drops the grant
        addVec(0,1,0,8'h81, 0,0,8'h81);
        addVec(0,0,0,8'h00, 1,7,8'h81);
        addVec(1,1,0,8'hFF, 0,0,8'h00);
        addVec(0,0,1,8'h00, 0,0,8'h00);
        // all ones drains highest first
        addVec(0,1,1,8'hFF, 0,0,8'hFF);
        addVec(0,0,1,8'h00, 1,7,8'hFF);
        addVec(0,0,1,8'h00, 1,6,8'h7F);
        addVec(0,0,1,8'h00, 1,5,8'h3F);
        addVec(0,0,1,8'h00, 1,4,8'h1F);
        addVec(0,0,1,8'h00, 1,3,8'h0F);
        addVec(0,0,1,8'h00, 1,2,8'h07);
        addVec(0,0,1,8'h00, 1,1,8'h03);
        addVec(0,0,1,8'h00, 1,0,8'h01);
        addVec(0,0,1,8'h00, 0,0,8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            expOh = vecs[i].valid ? (8'h01 << vecs[i].idx) : 8'h00;
            checkOutput($sformatf("row%0d valid", i), 32'(validA), 32'(vecs[i].valid));
            checkOutput($sformatf("row%0d idx", i), 32'(idxA), 32'(vecs[i].idx));
            checkOutput($sformatf("row%0d onehot", i), 32'(onehotA), 32'(expOh));
            checkOutput($sformatf("row%0d pending", i), 32'(pendA), 32'(vecs[i].pend));
        end

        // round-robin, level mode: two sources held alternate
        rstB = 1; enB = 1; reqB = 8'h81; readyB = 1;
        tick();
        tick();
        checkOutput("rr reset valid", 32'(validB), 0);
        checkOutput("rr reset pending", 32'(pendB), 0);
        rstB = 0;
        tick();
        checkOutput("rr81 warmup valid", 32'(validB), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("rr81 valid%0d", k), 32'(validB), 1);
            checkOutput($sformatf("rr81 grant%0d", k), 32'(idxB), (k % 2 == 0) ? 7 : 0);
        end

        // three sources rotate 7,2,0 rather than favouring the top
        exp85 = '{7, 2, 0, 7, 2, 0};
        rstB = 1; reqB = 8'h85;
        tick();
        rstB = 0;
        tick();
        checkOutput("rr85 warmup valid", 32'(validB), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("rr85 grant%0d", k), 32'(idxB), 32'(exp85[k]));
            checkOutput($sformatf("rr85 onehot%0d", k), 32'(onehotB), 32'(8'h01 << exp85[k]));
        end
        enB = 0;
        tick();
        checkOutput("level en0 pending", 32'(pendB), 0);
        tick();
        checkOutput("level en0 valid", 32'(validB), 0);

        // five-source instance never reports indices above 4
        tick();
        rstC = 0; enC = 1; reqC = 5'h1F;
        tick();
        checkOutput("odd pending", 32'(pendC), 32'h1F);
        checkOutput("odd warmup valid", 32'(validC), 0);
        enC = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("odd valid%0d", k), 32'(validC), 1);
            checkOutput($sformatf("odd idx%0d", k), 32'(idxC), 32'(4 - k));
            checkOutput($sformatf("odd onehot%0d", k), 32'(onehotC), 32'(5'h01 << (4 - k)));
        end
        tick();
        checkOutput("odd drained valid", 32'(validC), 0);
        checkOutput("odd drained idx", 32'(idxC), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
